// File: rtl/blit_pkg.sv
// Shared definitions for the blitter Gouraud/Z stepper.
package blit_pkg;

  localparam int unsigned PIX_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gstep_lane.sv
// One accumulator lane: holds a pixel value and advances it by a saturating add.
module gstep_lane
  import blit_pkg::*;
#(
  parameter int unsigned W = PIX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_init,
  input  logic         i_step,
  input  logic [W-1:0] i_inc,
  input  logic         i_sat,
  input  logic         i_eightbit,
  output logic [W-1:0] o_acc
);

  localparam int unsigned HI_W = W - 8;

  logic [W-1:0]    r_acc;
  logic [W:0]      w_sum_full;
  logic [8:0]      w_sum_lo;
  logic [HI_W-1:0] w_sum_hi;
  logic [7:0]      w_lo_res;
  logic [W-1:0]    w_full_res;
  logic [W-1:0]    w_next;

  // Saturating add: clamp when the carry disagrees with the increment sign
  always_comb begin
    w_sum_full = {1'b0, r_acc} + {1'b0, i_inc};
    w_sum_lo   = {1'b0, r_acc[7:0]} + {1'b0, i_inc[7:0]};
    w_sum_hi   = r_acc[W-1:8] + i_inc[W-1:8];
    w_full_res = w_sum_full[W-1:0];
    w_lo_res   = w_sum_lo[7:0];
    if (i_sat && (i_inc[W-1] ^ w_sum_full[W])) begin
      w_full_res = {W{w_sum_full[W]}};
    end
    if (i_sat && (i_inc[7] ^ w_sum_lo[8])) begin
      w_lo_res = {8{w_sum_lo[8]}};
    end
    w_next = i_eightbit ? {w_sum_hi, w_lo_res} : w_full_res;
  end

  // Accumulator register: load wins over step, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_init;
    end else if (i_step) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/blit_gouraud_stepper.sv
// Phrase-wide Gouraud intensity/Z stepper with load/count sequencing and valid/ready output.
module blit_gouraud_stepper
  import blit_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned W     = PIX_W,
  parameter int unsigned CNTW  = 16
) (
  input  logic               sys_clk,
  input  logic               resetl,
  input  logic               load,
  output logic               load_ready,
  input  logic [LANES*W-1:0] init,
  input  logic [W-1:0]       inc,
  input  logic [CNTW-1:0]    count,
  input  logic               sat,
  input  logic               eightbit,
  input  logic               abort,
  output logic [LANES*W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [W-1:0]    r_inc;
  logic            r_sat;
  logic            r_eightbit;
  logic            r_out_valid;
  logic            r_busy;
  logic            r_done;
  logic            r_load_ready;

  logic            w_count_zero;
  logic            w_lane_load;
  logic            w_step;

  assign w_count_zero = (count == '0);
  assign w_lane_load  = (r_state == IDLE) && load && !abort && !w_count_zero;
  assign w_step       = (r_state == RUN) && out_ready && !abort;

  // Lane array: each lane owns its accumulator and saturating adder
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gstep_lane #(.W(W)) u_lane (
      .clk        (sys_clk),
      .rst_n      (resetl),
      .i_load     (w_lane_load),
      .i_init     (init[k*W +: W]),
      .i_step     (w_step),
      .i_inc      (r_inc),
      .i_sat      (r_sat),
      .i_eightbit (r_eightbit),
      .o_acc      (out_data[k*W +: W])
    );
  end

  // Sequencer: state, phrase counter, latched mode bits and registered status outputs
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_inc        <= '0;
      r_sat        <= 1'b0;
      r_eightbit   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state      <= IDLE;
        r_out_valid  <= 1'b0;
        r_busy       <= 1'b0;
        r_load_ready <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (load) begin
              r_inc        <= inc;
              r_sat        <= sat;
              r_eightbit   <= eightbit;
              r_busy       <= 1'b1;
              r_load_ready <= 1'b0;
              if (w_count_zero) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state     <= RUN;
                r_cnt       <= count;
                r_out_valid <= 1'b1;
              end
            end
          end
          RUN: begin
            if (out_ready) begin
              r_cnt <= r_cnt - CNTW'(1);
              if (r_cnt == CNTW'(1)) begin
                r_state     <= DONE;
                r_out_valid <= 1'b0;
                r_done      <= 1'b1;
              end
            end
          end
          DONE: begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
          end
          default: begin
            r_state      <= IDLE;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign load_ready = r_load_ready;

endmodule
